// File: rtl/chs_pkg.sv
// Shared state encoding, default parameters and the error helper for the
// climate heating/cooling sequencer.
package chs_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RAMP_UP   = 3'd1,
    ST_RUN       = 3'd2,
    ST_RAMP_DOWN = 3'd3,
    ST_LOCKOUT   = 3'd4
  } chs_state_e;

  localparam int unsigned DEF_TICK_DIV      = 1000;
  localparam int unsigned DEF_SPEED_STEP    = 8;
  localparam int unsigned DEF_SPEED_MAX     = 255;
  localparam int unsigned DEF_HYST          = 2;
  localparam int unsigned DEF_LOCKOUT_TICKS = 30;

  // |a - b| computed in 9-bit signed so neither operand order wraps.
  function automatic logic [8:0] abs_err(input logic [7:0] a, input logic [7:0] b);
    logic signed [8:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    return d[8] ? $unsigned(-d) : $unsigned(d);
  endfunction

endpackage

// File: rtl/chs_tick_gen.sv
// Control-tick prescaler: tick is high for one clk out of every TICK_DIV.
module chs_tick_gen #(
  parameter int unsigned TICK_DIV = chs_pkg::DEF_TICK_DIV
) (
  input  logic clk,
  input  logic arst,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/chs_controller.sv
// Fan/degree sequencer: ramps duty up, holds while tracking the setpoint,
// ramps down, then enforces a lockout before the next cycle.
module chs_controller
  import chs_pkg::*;
#(
  parameter int unsigned TICK_DIV      = DEF_TICK_DIV,
  parameter int unsigned SPEED_STEP    = DEF_SPEED_STEP,
  parameter int unsigned SPEED_MAX     = DEF_SPEED_MAX,
  parameter int unsigned HYST          = DEF_HYST,
  parameter int unsigned LOCKOUT_TICKS = DEF_LOCKOUT_TICKS
) (
  input  logic       clk,
  input  logic       arst,
  input  logic       enable,
  input  logic [7:0] cur_temp,
  input  logic [7:0] set_temp,
  output logic [7:0] speed,
  output logic [7:0] chs_conf,
  output logic       heat,
  output logic       active,
  output logic [2:0] state
);

  localparam int unsigned LW = (LOCKOUT_TICKS > 1) ? $clog2(LOCKOUT_TICKS + 1) : 1;
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCKOUT_TICKS - 1);
  localparam logic [7:0]    SMAX      = 8'(SPEED_MAX);

  logic tick;

  chs_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .arst (arst),
    .tick (tick)
  );

  chs_state_e    state_q;
  logic [7:0]    speed_q, conf_q;
  logic          heat_q, active_q;
  logic [LW-1:0] lock_q;

  logic [8:0] inc9, dec9;
  logic [7:0] spd_up, spd_dn;
  logic       start_ok, reversed;

  // Ramp steps are formed in 9 bits so overshoot clamps instead of wrapping.
  always_comb begin
    inc9     = {1'b0, speed_q} + 9'(SPEED_STEP);
    dec9     = {1'b0, speed_q} - 9'(SPEED_STEP);
    spd_up   = (inc9 > {1'b0, SMAX}) ? SMAX : inc9[7:0];
    spd_dn   = dec9[8] ? '0 : dec9[7:0];
    start_ok = abs_err(cur_temp, set_temp) > 9'(HYST);
    reversed = heat_q ? (cur_temp > set_temp) : (cur_temp < set_temp);
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state_q  <= ST_IDLE;
      speed_q  <= '0;
      conf_q   <= '0;
      heat_q   <= 1'b0;
      active_q <= 1'b0;
      lock_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (tick && enable && start_ok) begin
            state_q  <= ST_RAMP_UP;
            heat_q   <= (cur_temp < set_temp);
            conf_q   <= set_temp;
            active_q <= 1'b1;
          end
        end
        ST_RAMP_UP: begin
          if (!enable) begin
            state_q <= ST_RAMP_DOWN;
          end else if (tick) begin
            speed_q <= spd_up;
            if (spd_up == SMAX) state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (!enable) begin
            state_q <= ST_RAMP_DOWN;
          end else if (tick) begin
            conf_q <= set_temp;
            if ((cur_temp == set_temp) || reversed) state_q <= ST_RAMP_DOWN;
          end
        end
        ST_RAMP_DOWN: begin
          if (tick) begin
            speed_q <= spd_dn;
            if (spd_dn == '0) begin
              state_q  <= ST_LOCKOUT;
              lock_q   <= '0;
              active_q <= 1'b0;
            end
          end
        end
        ST_LOCKOUT: begin
          if (tick) begin
            if (lock_q == LOCK_LAST) begin
              state_q <= ST_IDLE;
              lock_q  <= '0;
            end else begin
              lock_q <= lock_q + LW'(1);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign speed    = speed_q;
  assign chs_conf = conf_q;
  assign heat     = heat_q;
  assign active   = active_q;
  assign state    = state_q;

endmodule

// File: tb/tb_chs_controller.sv
// Directed bench for chs_controller with a cycle-level reference model and
// hand-computed checkpoints along each scenario.
module tb_chs_controller;

  localparam int TD   = 4;
  localparam int STEP = 64;
  localparam int SMAX = 255;
  localparam int HY   = 2;
  localparam int LOCK = 30;

  localparam int M_IDLE = 0, M_UP = 1, M_RUN = 2, M_DOWN = 3, M_LOCK = 4;

  logic       clk = 1'b0;
  logic       arst = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] cur_temp = '0, set_temp = '0;
  logic [7:0] speed, chs_conf;
  logic       heat, active;
  logic [2:0] state;

  int n_chk = 0;
  int n_fail = 0;

  chs_controller #(
    .TICK_DIV(TD), .SPEED_STEP(STEP), .SPEED_MAX(SMAX), .HYST(HY), .LOCKOUT_TICKS(LOCK)
  ) dut (
    .clk(clk), .arst(arst), .enable(enable), .cur_temp(cur_temp), .set_temp(set_temp),
    .speed(speed), .chs_conf(chs_conf), .heat(heat), .active(active), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: cycle count since reset decides ticks; ramps use
  // integer min/max; lockout counts down the ticks remaining.
  int m_cyc, m_mode, m_speed, m_conf, m_left;
  bit m_heat, m_ticked;

  always @(posedge clk or negedge arst) begin
    if (!arst) begin
      m_cyc = 0; m_mode = M_IDLE; m_speed = 0; m_conf = 0; m_heat = 0;
      m_left = 0; m_ticked = 0;
    end else begin
      int c, s, e;
      bit t;
      t = ((m_cyc % TD) == TD - 1);
      m_cyc++;
      m_ticked = t;
      c = cur_temp; s = set_temp;
      e = (c > s) ? c - s : s - c;
      if (m_mode == M_IDLE) begin
        if (t && enable && e > HY) begin
          m_mode = M_UP; m_heat = (c < s); m_conf = s;
        end
      end else if (m_mode == M_UP || m_mode == M_RUN) begin
        if (!enable) m_mode = M_DOWN;
        else if (t && m_mode == M_UP) begin
          m_speed = (m_speed + STEP > SMAX) ? SMAX : m_speed + STEP;
          if (m_speed == SMAX) m_mode = M_RUN;
        end else if (t) begin
          m_conf = s;
          if (c == s || (m_heat && c > s) || (!m_heat && c < s)) m_mode = M_DOWN;
        end
      end else if (m_mode == M_DOWN) begin
        if (t) begin
          m_speed = (m_speed < STEP) ? 0 : m_speed - STEP;
          if (m_speed == 0) begin m_mode = M_LOCK; m_left = LOCK; end
        end
      end else if (t) begin
        m_left--;
        if (m_left == 0) m_mode = M_IDLE;
      end
    end
  end

  always @(negedge clk) begin
    chk("model_speed",  speed,    m_speed);
    chk("model_conf",   chs_conf, m_conf);
    chk("model_heat",   heat,     m_heat);
    chk("model_active", active,   (m_mode >= M_UP && m_mode <= M_DOWN));
    chk("model_state",  state,    m_mode);
  end

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      int g = 0;
      do begin
        @(negedge clk);
        g++;
      end while (!m_ticked && g < 4 * TD);
      if (!m_ticked) chk("tick_timeout", 0, 1);
    end
  endtask

  task automatic pin(input string name, input int st, input int sp);
    chk({name, "_state"}, state, st);
    chk({name, "_speed"}, speed, sp);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    pin("reset", M_IDLE, 0);
    chk("reset_conf", chs_conf, 0);
    chk("reset_heat", heat, 0);
    chk("reset_active", active, 0);

    // Cool cycle: set=20, cur=25.
    set_temp = 20; cur_temp = 25; enable = 1;
    #2 arst = 1;
    wait_ticks(1);
    pin("cool_start", M_UP, 0);
    chk("cool_heat", heat, 0);
    chk("cool_conf", chs_conf, 20);
    chk("cool_active", active, 1);
    wait_ticks(1); pin("up1", M_UP, 64);
    wait_ticks(1); pin("up2", M_UP, 128);
    wait_ticks(1); pin("up3", M_UP, 192);
    wait_ticks(1); pin("up4", M_RUN, 255);
    cur_temp = 20;
    wait_ticks(1); pin("run_exit", M_DOWN, 255);
    wait_ticks(1); pin("dn1", M_DOWN, 191);
    wait_ticks(1); pin("dn2", M_DOWN, 127);
    wait_ticks(1); pin("dn3", M_DOWN, 63);
    wait_ticks(1); pin("dn4", M_LOCK, 0);
    chk("lock_active", active, 0);
    wait_ticks(LOCK - 1); pin("lock_end_minus1", M_LOCK, 0);
    wait_ticks(1); pin("lock_done", M_IDLE, 0);

    // Error equal to the band holds IDLE; one degree more starts a heat cycle.
    cur_temp = 22;
    wait_ticks(8); pin("band_hold", M_IDLE, 0);
    cur_temp = 17;
    wait_ticks(1); pin("heat_start", M_UP, 0);
    chk("heat_latched", heat, 1);
    wait_ticks(2); pin("heat_up2", M_UP, 128);

    // Enable drop in RAMP_UP reacts on the next clk.
    enable = 0;
    @(negedge clk); pin("en_drop", M_DOWN, 128);
    wait_ticks(1); pin("en_dn1", M_DOWN, 64);
    wait_ticks(1); pin("en_dn2", M_LOCK, 0);
    enable = 1;
    wait_ticks(LOCK - 1); pin("en_lock_hold", M_LOCK, 0);
    wait_ticks(1); pin("en_lock_done", M_IDLE, 0);
    wait_ticks(1); pin("heat2_start", M_UP, 0);
    wait_ticks(4); pin("heat2_run", M_RUN, 255);

    // Setpoint moved below cur while heating reverses the error.
    set_temp = 15;
    wait_ticks(1); pin("rev_exit", M_DOWN, 255);
    chk("rev_heat", heat, 1);
    chk("rev_conf", chs_conf, 15);
    wait_ticks(4); pin("rev_lock", M_LOCK, 0);
    wait_ticks(LOCK); pin("rev_idle", M_IDLE, 0);
    wait_ticks(3); pin("rev_band", M_IDLE, 0);
    chk("rev_heat_held", heat, 1);
    cur_temp = 25;
    wait_ticks(1); pin("cool2_start", M_UP, 0);
    chk("cool2_heat", heat, 0);
    wait_ticks(4); pin("cool2_run", M_RUN, 255);

    // Reset between ticks in RUN.
    @(negedge clk);
    #2 arst = 0;
    #1;
    pin("arst_mid", M_IDLE, 0);
    chk("arst_active", active, 0);
    chk("arst_conf", chs_conf, 0);
    repeat (3) @(negedge clk);
    cur_temp = 30; set_temp = 20;
    #2 arst = 1;
    wait_ticks(1); pin("post_rst_start", M_UP, 0);
    chk("post_rst_conf", chs_conf, 20);
    chk("post_rst_heat", heat, 0);
    wait_ticks(4); pin("post_rst_run", M_RUN, 255);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/chs_controller.md
CHS_CONTROLLER -- requirements
Module: chs_controller

Interface
REQ-001 Parameter TICK_DIV, 1000, clk cycles per control tick (>=2).
REQ-002 Parameter SPEED_STEP, 8, duty increment/decrement per tick during ramps.
REQ-003 Parameter SPEED_MAX, 255, run-state fan duty.
REQ-004 Parameter HYST, 2, degrees of error tolerated before a cycle starts.
REQ-005 Parameter LOCKOUT_TICKS, 30, minimum ticks between cycle end and next start.
REQ-006 clk  input  1  clock, posedge.
REQ-007 arst  input  1  reset, asynchronous, active-low.
REQ-008 enable  input  1  system on; low requests shutdown.
REQ-009 cur_temp  input  8  measured temperature, unsigned degrees.
REQ-010 set_temp  input  8  target temperature, unsigned degrees.
REQ-011 speed  output  8  fan duty to the PWM generator.
REQ-012 chs_conf  output  8  degree request to the mode/power decoder.
REQ-013 heat  output  1  latched direction, heat=1 / cool=0.
REQ-014 active  output  1  high in any state except IDLE and LOCKOUT.
REQ-015 state  output  3  current FSM state code, for debug.

Function
REQ-016 Internal prescaler SHALL pulse tick for one clk every TICK_DIV cycles; all FSM transitions except enable-low SHALL occur only on tick.
REQ-017 States SHALL be IDLE, RAMP_UP, RUN, RAMP_DOWN, LOCKOUT.
REQ-018 IDLE->RAMP_UP on tick when enable=1 and |cur_temp-set_temp| > HYST, using 9-bit signed difference with no wrap.
REQ-019 On entering RAMP_UP the block SHALL latch heat = (cur_temp < set_temp) and chs_conf = set_temp.
REQ-020 RAMP_UP: speed += SPEED_STEP per tick, saturating at SPEED_MAX; go to RUN on the tick speed reaches SPEED_MAX.
REQ-021 RUN: chs_conf SHALL track set_temp each tick; go to RAMP_DOWN when cur_temp == set_temp, the error sign reverses against heat, or enable=0.
REQ-022 RAMP_DOWN: speed -= SPEED_STEP per tick, saturating at 0; go to LOCKOUT on the tick speed reaches 0.
REQ-023 LOCKOUT: count LOCKOUT_TICKS ticks with speed=0, then return to IDLE; no new cycle may start inside LOCKOUT.
REQ-024 enable=0 in RAMP_UP SHALL move to RAMP_DOWN on the next clk, without waiting for a tick; speed continues from its current value.
REQ-025 chs_conf and heat SHALL be held constant in RAMP_DOWN, LOCKOUT and IDLE.
REQ-026 Temperature that re-enters the band during RAMP_UP SHALL NOT abort the ramp; it is evaluated in RUN.
REQ-027 Ramp arithmetic SHALL use 9-bit intermediates so overshoot past 0/SPEED_MAX clamps and never wraps.

Reset
REQ-028 arst low SHALL asynchronously force state=IDLE, speed=0, chs_conf=0, heat=0, active=0, prescaler=0 and lockout counter=0.
REQ-029 Reset asserted mid-cycle SHALL drop speed to 0 immediately, with no ramp-down; after release the first cycle may start on the first qualifying tick, with no lockout.

Structure
REQ-030 State encoding and default parameter constants SHALL live in a shared package chs_pkg.
REQ-031 The prescaler SHALL be a separate sub-module chs_tick_gen (parameter TICK_DIV, outputs tick).
REQ-032 No combinational path from cur_temp, set_temp or enable to any output; all outputs registered.

Verification
REQ-033 TICK_DIV=4, STEP=64, MAX=255, set=20, cur=25, enable=1 -> cool cycle (heat=0, chs_conf=20); speed 64,128,192,255 on successive ticks; then RUN.
REQ-034 In RUN, set cur=20 -> speed 191,127,63,0 on successive ticks; then LOCKOUT of exactly LOCKOUT_TICKS ticks, IDLE, active=0 throughout LOCKOUT.
REQ-035 set=20, cur=22 (|err|=HYST) -> stays IDLE indefinitely; cur=17 -> heat=1 cycle starts on next tick.
REQ-036 Drop enable during RAMP_UP at speed=128 -> RAMP_DOWN on next clk; speed 64, 0 on successive ticks; then LOCKOUT.
REQ-037 Assert arst in RUN between ticks -> same-cycle speed=0, state=IDLE; release with cur=30, set=20 -> new cycle begins on first tick.
REQ-038 In RUN heat=1, set set_temp below cur_temp -> RAMP_DOWN on next tick; heat stays 1 until the next cycle latches 0.
